alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one registered 32-bit ALU (3-bit OP, registered X/Z outputs, one-cycle latency) between two requesters.
- Round-robin arbitration with a valid/ready command channel per requester.
- Sequences each operation through the ALU, holding operands stable for the ALU latency, and captures the result and zero flag.
- Returns the result on a single valid/ready response channel tagged with the requester ID.

Parameters:
- LAT, 1, ALU latency in cycles from operands applied to result visible on alu_x/alu_z (legal range 1..15).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle when high together with valid.
- req0_a, req0_b  in  32  requester 0 operands.
- req0_op  in  3  requester 0 ALU opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as the requester 0 ports, for requester 1.
- alu_a, alu_b  out  32  operands to the ALU.
- alu_op  out  3  opcode to the ALU.
- alu_x  in  32  ALU result.
- alu_z  in  1  ALU zero flag.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_x  out  32  captured result.
- resp_z  out  1  captured zero flag.
- resp_id  out  1  requester that issued the command.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values:
  - State IDLE; rr_last=1, so requester 0 wins the first contention.
  - alu_a, alu_b, alu_op, resp_x = 0; resp_z = 0; resp_id = 0.
  - resp_valid = 0; busy = 0; both reqN_ready = 0.
- States: IDLE -> EXEC -> CAPT -> RESP -> IDLE.
- IDLE:
  - Grant is combinational.
  - If only one requester is valid, it is granted.
  - If both are valid, grant goes to the requester != rr_last.
  - reqN_ready = 1 only for the granted requester, and only in IDLE; never high in any other state.
  - On handshake: latch a, b, op into alu_a/alu_b/alu_op; latch the ID into resp_id and rr_last; load wait counter with LAT; go to EXEC.
- EXEC:
  - alu_a/alu_b/alu_op held constant.
  - Counter decrements each cycle; on the cycle it equals 1, go to CAPT.
  - EXEC therefore lasts exactly LAT cycles.
- CAPT:
  - Operands still held.
  - At the end of this cycle, resp_x <= alu_x and resp_z <= alu_z; go to RESP.
- RESP:
  - resp_valid = 1; resp_x/resp_z/resp_id are stable until the handshake.
  - On resp_valid && resp_ready, go to IDLE. resp_valid drops in the following cycle.
  - No new command is accepted in the handshake cycle.
- Latency:
  - The accept edge is cycle T.
  - resp_valid is first high in cycle T+LAT+2 (LAT=1: accept at T, resp_valid at T+3).
  - Minimum issue interval is LAT+3 cycles with resp_ready tied high.
- alu_* outputs hold their last command after completion; they do not return to 0 in IDLE.
- The block never modifies results. OP 3'b111 is passed through, and the ALU returns 0 with Z=1.
- Back-pressure: resp_ready low holds RESP indefinitely. Requesters see ready=0 during that time; no command is dropped or overwritten.
- A requester that deasserts valid without a handshake loses nothing. The grant is re-evaluated every IDLE cycle.
- rr_last updates only on an accepted command, never on a mere grant.
- Reset mid-operation (any state):
  - Immediate return to IDLE and all reset values.
  - The in-flight result is discarded; no response is ever issued for it.
- Reset has no ordering requirement relative to the ALU's own reset. The captured value is only sampled in CAPT.

Test Plan:
- Single op: req0 a=5, b=7, op=000, resp_ready=1 -> resp_valid 3 cycles after accept; resp_x=12, resp_z=0, resp_id=0; busy high from accept+1 until the response handshake.
- Zero flag: req1 a=9, b=9, op=001 -> resp_x=0, resp_z=1, resp_id=1. Then op=111 with a=3, b=4 -> resp_x=0, resp_z=1.
- Contention fairness: both valid continuously, req0 op=011 a=F0, req1 op=101 a=FF, b=0F, resp_ready=1 -> order id 0,1,0,1; results 0xFF and 0x0F; reqN_ready never high in both at once.
- Back-pressure: after a response, hold resp_ready=0 for 5 cycles with req0 valid -> resp_valid and resp_x stable, req0_ready stays 0; release -> IDLE next cycle, then req0 accepted.
- Reset mid-op: assert reset while in EXEC -> resp_valid=0, busy=0, alu_* = 0 asynchronously; no response is produced after release; the next req0 command (a=1, b=1, op=000) returns 2.
- LAT=3 build: a=0xFFFFFFFF, b=1, op=000 -> operands stable for 4 cycles; resp_x=0, resp_z=1; resp_valid at accept+5.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters.
// Round-robin grant, one command in flight, result returned on a single
// response channel tagged with the issuing requester's ID.
//
// Handshake rule for every channel here: a transfer happens on a rising
// clock edge where valid and ready are both high. The producer keeps valid
// (and its payload) stable until that edge. ready can depend combinationally
// on valid, but valid never depends on ready.
module alu_arbiter #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_x,
  input  logic        alu_z,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_x,
  output logic        resp_z,
  output logic        resp_id,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Counter width covers the full legal LAT range of 1..15.
  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t      state;
  state_t      state_nxt;
  logic        rr_last;
  logic [3:0]  wait_cnt;
  logic        gnt_valid;
  logic        gnt_id;
  logic        accept;

  // Grant: a lone requester wins; under contention the one not served last wins.
  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    gnt_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id = ~rr_last;
    end else if (req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  // Next-state and handshake outputs; ready only ever asserts in IDLE.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          accept     = 1'b1;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        if (wait_cnt == 4'd1) begin
          state_nxt = CAPT;
        end
      end
      CAPT: begin
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand latch, arbitration history, latency counter and result capture.
  // alu_* deliberately keep the last command after completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      resp_x   <= '0;
      resp_z   <= 1'b0;
      resp_id  <= 1'b0;
      rr_last  <= 1'b1;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a    <= gnt_id ? req1_a  : req0_a;
            alu_b    <= gnt_id ? req1_b  : req0_b;
            alu_op   <= gnt_id ? req1_op : req0_op;
            resp_id  <= gnt_id;
            rr_last  <= gnt_id;
            wait_cnt <= LAT_CNT;
          end
        end
        EXEC: begin
          wait_cnt <= wait_cnt - 4'd1;
        end
        CAPT: begin
          resp_x <= alu_x;
          resp_z <= alu_z;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a LAT=1 instance drives most scenarios,
// a LAT=3 instance covers the longer latency build. Each instance gets a
// small registered ALU model with the matching pipeline depth.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;

  // LAT=1 instance signals
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_op;
  logic [31:0] alu_a, alu_b, alu_x;
  logic [2:0]  alu_op;
  logic        alu_z;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_x;
  logic        resp_z, resp_id, busy;
  logic [1:0]  dbg_state;

  // LAT=3 instance signals
  logic        d3_valid, d3_ready;
  logic [31:0] d3_a, d3_b;
  logic [2:0]  d3_op;
  logic        d3_req1_valid, d3_req1_ready;
  logic [31:0] d3_req1_a, d3_req1_b;
  logic [2:0]  d3_req1_op;
  logic [31:0] d3_alu_a, d3_alu_b, d3_alu_x;
  logic [2:0]  d3_alu_op;
  logic        d3_alu_z;
  logic        d3_resp_valid, d3_resp_ready;
  logic [31:0] d3_resp_x;
  logic        d3_resp_z, d3_resp_id, d3_busy;
  logic [1:0]  d3_dbg_state;

  int n_checks;
  int n_pass;

  alu_arbiter #(.LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_x(alu_x), .alu_z(alu_z),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_x(resp_x), .resp_z(resp_z), .resp_id(resp_id),
    .busy(busy), .dbg_state(dbg_state)
  );

  alu_arbiter #(.LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(d3_valid), .req0_ready(d3_ready),
    .req0_a(d3_a), .req0_b(d3_b), .req0_op(d3_op),
    .req1_valid(d3_req1_valid), .req1_ready(d3_req1_ready),
    .req1_a(d3_req1_a), .req1_b(d3_req1_b), .req1_op(d3_req1_op),
    .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_op(d3_alu_op),
    .alu_x(d3_alu_x), .alu_z(d3_alu_z),
    .resp_valid(d3_resp_valid), .resp_ready(d3_resp_ready),
    .resp_x(d3_resp_x), .resp_z(d3_resp_z), .resp_id(d3_resp_id),
    .busy(d3_busy), .dbg_state(d3_dbg_state)
  );

  // ALU function: {z, x}. 111 yields 0 with Z set.
  function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    logic [31:0] x;
    case (op)
      3'b000: x = a + b;
      3'b001: x = a - b;
      3'b010: x = a ^ b;
      3'b011: x = a | b;
      3'b100: x = a << b[4:0];
      3'b101: x = a & b;
      3'b110: x = ~a;
      default: x = 32'd0;
    endcase
    return {(x == 32'd0), x};
  endfunction

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-stage registered ALU for the LAT=1 instance.
  always @(posedge clk) {alu_z, alu_x} <= alu_f(alu_a, alu_b, alu_op);

  // Three-stage registered ALU for the LAT=3 instance.
  logic [32:0] p1, p2;
  always @(posedge clk) begin
    p1 <= alu_f(d3_alu_a, d3_alu_b, d3_alu_op);
    p2 <= p1;
    {d3_alu_z, d3_alu_x} <= p2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command on the LAT=1 instance and wait for its response.
  // lat counts cycles from the handshake cycle to the first resp_valid cycle.
  task automatic send(input logic id, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, output logic ok, output int lat);
    int k;
    ok  = 1'b0;
    lat = 0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    k = 0;
    while (!(id ? req1_ready : req0_ready) && k < 30) begin
      tick();
      k++;
    end
    if (!(id ? req1_ready : req0_ready)) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      return;
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      tick();
      lat++;
    end
    ok = resp_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); else n_pass++;
    n_checks++; if ({alu_a, alu_b, alu_op} !== 67'd0) $display("FAIL reset_alu got=%h/%h/%h exp=0", alu_a, alu_b, alu_op); else n_pass++;
    n_checks++; if ({resp_x, resp_z, resp_id} !== 34'd0) $display("FAIL reset_resp got=%h/%b/%b exp=0", resp_x, resp_z, resp_id); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", dbg_state); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int k;
    int lat;
    int stable;
    int busy_bad;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 3'b000;
    #1;
    k = 0;
    while (!req0_ready && k < 30) begin tick(); k++; end
    n_checks++; if (req0_ready !== 1'b1) $display("FAIL single_ready got=%0b exp=1", req0_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_idle got=%0b exp=0", busy); else n_pass++;
    tick();
    req0_valid = 1'b0;
    lat = 1; stable = 0; busy_bad = 0;
    while (!resp_valid && lat < 40) begin
      if (alu_a === 32'd5 && alu_b === 32'd7 && alu_op === 3'b000) stable++;
      if (busy !== 1'b1) busy_bad++;
      tick();
      lat++;
    end
    n_checks++; if (lat !== 3) $display("FAIL single_latency got=%0d exp=3", lat); else n_pass++;
    n_checks++; if (stable !== 2) $display("FAIL single_operand_hold got=%0d exp=2", stable); else n_pass++;
    n_checks++; if (busy_bad !== 0) $display("FAIL single_busy_flight got=%0d exp=0", busy_bad); else n_pass++;
    n_checks++; if (resp_x !== 32'd12) $display("FAIL single_x got=%0d exp=12", resp_x); else n_pass++;
    n_checks++; if (resp_z !== 1'b0) $display("FAIL single_z got=%0b exp=0", resp_z); else n_pass++;
    n_checks++; if (resp_id !== 1'b0) $display("FAIL single_id got=%0b exp=0", resp_id); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_resp got=%0b exp=1", busy); else n_pass++;
    tick();
    n_checks++; if ({busy, resp_valid} !== 2'b00) $display("FAIL single_after_hs got=%b exp=00", {busy, resp_valid}); else n_pass++;
    n_checks++; if (alu_a !== 32'd5) $display("FAIL single_alu_hold got=%0d exp=5", alu_a); else n_pass++;
  endtask

  task automatic test_zero_flag();
    logic ok;
    int lat;
    send(1'b1, 32'd9, 32'd9, 3'b001, ok, lat);
    n_checks++; if (ok !== 1'b1) $display("FAIL zero_sub_timeout got=%0b exp=1", ok); else n_pass++;
    n_checks++; if ({resp_x, resp_z, resp_id} !== {32'd0, 1'b1, 1'b1}) $display("FAIL zero_sub got=%h/%b/%b exp=0/1/1", resp_x, resp_z, resp_id); else n_pass++;
    tick();
    send(1'b1, 32'd3, 32'd4, 3'b111, ok, lat);
    n_checks++; if (ok !== 1'b1) $display("FAIL zero_op7_timeout got=%0b exp=1", ok); else n_pass++;
    n_checks++; if ({resp_x, resp_z} !== {32'd0, 1'b1}) $display("FAIL zero_op7 got=%h/%b exp=0/1", resp_x, resp_z); else n_pass++;
    n_checks++; if (alu_op !== 3'b111) $display("FAIL zero_op7_pass got=%b exp=111", alu_op); else n_pass++;
    tick();
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_ids;
    int seen;
    int cyc;
    int last_cyc;
    int overlap;
    exp_ids = 2'b10;
    req0_valid = 1'b1; req0_a = 32'hF0; req0_b = 32'h0F; req0_op = 3'b011;
    req1_valid = 1'b1; req1_a = 32'hFF; req1_b = 32'h0F; req1_op = 3'b101;
    #1;
    seen = 0; cyc = 0; last_cyc = 0; overlap = 0;
    while (seen < 4 && cyc < 100) begin
      if (req0_ready && req1_ready) overlap++;
      if (resp_valid) begin
        n_checks++; if (resp_id !== exp_ids[seen % 2]) $display("FAIL fair_id[%0d] got=%0b exp=%0b", seen, resp_id, exp_ids[seen % 2]); else n_pass++;
        n_checks++;
        if (resp_x !== (exp_ids[seen % 2] ? 32'h0F : 32'hFF)) $display("FAIL fair_x[%0d] got=%h exp=%h", seen, resp_x, exp_ids[seen % 2] ? 32'h0F : 32'hFF);
        else n_pass++;
        if (seen > 0) begin
          n_checks++; if (cyc - last_cyc !== 4) $display("FAIL fair_interval[%0d] got=%0d exp=4", seen, cyc - last_cyc); else n_pass++;
        end
        last_cyc = cyc;
        seen++;
      end
      tick();
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_checks++; if (seen !== 4) $display("FAIL fair_count got=%0d exp=4", seen); else n_pass++;
    n_checks++; if (overlap !== 0) $display("FAIL fair_ready_overlap got=%0d exp=0", overlap); else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    logic ok;
    int lat;
    int k;
    resp_ready = 1'b0;
    send(1'b0, 32'd10, 32'd20, 3'b000, ok, lat);
    n_checks++; if (ok !== 1'b1) $display("FAIL bp_timeout got=%0b exp=1", ok); else n_pass++;
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_op = 3'b000;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (resp_valid !== 1'b1) $display("FAIL bp_valid[%0d] got=%0b exp=1", i, resp_valid); else n_pass++;
      n_checks++; if (resp_x !== 32'd30) $display("FAIL bp_x[%0d] got=%0d exp=30", i, resp_x); else n_pass++;
      n_checks++; if (req0_ready !== 1'b0) $display("FAIL bp_ready[%0d] got=%0b exp=0", i, req0_ready); else n_pass++;
      tick();
    end
    resp_ready = 1'b1;
    tick();
    n_checks++; if ({busy, resp_valid, req0_ready} !== 3'b001) $display("FAIL bp_release got=%b exp=001", {busy, resp_valid, req0_ready}); else n_pass++;
    tick();
    req0_valid = 1'b0;
    n_checks++; if ({busy, alu_a} !== {1'b1, 32'd2}) $display("FAIL bp_accept got=%b/%0d exp=1/2", busy, alu_a); else n_pass++;
    k = 0;
    while (!resp_valid && k < 40) begin tick(); k++; end
    n_checks++; if (resp_x !== 32'd5) $display("FAIL bp_next_x got=%0d exp=5", resp_x); else n_pass++;
    tick();
  endtask

  task automatic test_reset_midop();
    logic ok;
    int lat;
    int k;
    int spurious;
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd200; req0_op = 3'b000;
    #1;
    k = 0;
    while (!req0_ready && k < 30) begin tick(); k++; end
    tick();
    req0_valid = 1'b0;
    n_checks++; if (dbg_state !== 2'd1) $display("FAIL rst_in_exec got=%0d exp=1", dbg_state); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if ({resp_valid, busy} !== 2'b00) $display("FAIL rst_async_ctl got=%b exp=00", {resp_valid, busy}); else n_pass++;
    n_checks++; if ({alu_a, alu_b, alu_op} !== 67'd0) $display("FAIL rst_async_alu got=%h/%h/%h exp=0", alu_a, alu_b, alu_op); else n_pass++;
    tick();
    reset = 1'b0;
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) spurious++;
      tick();
    end
    n_checks++; if (spurious !== 0) $display("FAIL rst_no_resp got=%0d exp=0", spurious); else n_pass++;
    send(1'b0, 32'd1, 32'd1, 3'b000, ok, lat);
    n_checks++; if (ok !== 1'b1) $display("FAIL rst_next_timeout got=%0b exp=1", ok); else n_pass++;
    n_checks++; if ({resp_x, resp_id} !== {32'd2, 1'b0}) $display("FAIL rst_next got=%0d/%0b exp=2/0", resp_x, resp_id); else n_pass++;
    tick();
  endtask

  task automatic test_lat3();
    int k;
    int lat;
    int stable;
    int busy_bad;
    d3_valid = 1'b1; d3_a = 32'hFFFF_FFFF; d3_b = 32'd1; d3_op = 3'b000;
    #1;
    k = 0;
    while (!d3_ready && k < 30) begin tick(); k++; end
    n_checks++; if (d3_ready !== 1'b1) $display("FAIL lat3_ready got=%0b exp=1", d3_ready); else n_pass++;
    tick();
    d3_valid = 1'b0;
    lat = 1; stable = 0; busy_bad = 0;
    while (!d3_resp_valid && lat < 40) begin
      if (d3_alu_a === 32'hFFFF_FFFF && d3_alu_b === 32'd1 && d3_alu_op === 3'b000) stable++;
      if (d3_busy !== 1'b1 || d3_ready !== 1'b0 || d3_req1_ready !== 1'b0) busy_bad++;
      tick();
      lat++;
    end
    n_checks++; if (lat !== 5) $display("FAIL lat3_latency got=%0d exp=5", lat); else n_pass++;
    n_checks++; if (stable !== 4) $display("FAIL lat3_operand_hold got=%0d exp=4", stable); else n_pass++;
    n_checks++; if (busy_bad !== 0) $display("FAIL lat3_busy_flight got=%0d exp=0", busy_bad); else n_pass++;
    n_checks++; if ({d3_resp_x, d3_resp_z, d3_resp_id} !== {32'd0, 1'b1, 1'b0}) $display("FAIL lat3_result got=%h/%b/%b exp=0/1/0", d3_resp_x, d3_resp_z, d3_resp_id); else n_pass++;
    tick();
    n_checks++; if (d3_dbg_state !== 2'd0) $display("FAIL lat3_idle got=%0d exp=0", d3_dbg_state); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    resp_ready = 1'b1;
    d3_valid = 1'b0; d3_a = '0; d3_b = '0; d3_op = '0;
    d3_req1_valid = 1'b0; d3_req1_a = '0; d3_req1_b = '0; d3_req1_op = '0;
    d3_resp_ready = 1'b1;

    test_reset();
    test_single();
    test_zero_flag();
    test_fairness();
    test_backpressure();
    test_reset_midop();
    test_lat3();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
